// File: rtl/bit_serial_adder_if.sv
// Handshake and operand bundle for bit_serial_adder.
// master issues operations, slave is the adder.
interface bit_serial_adder_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial add/sub: DIGIT bits per cycle, LSB first,
// WIDTH/DIGIT cycles per op, start/busy/done framing.
module bit_serial_adder #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst_n,
  bit_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("bit_serial_adder: DIGIT must divide WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic             carry;
  logic [DIGIT:0]   dsum;
  logic             last;
  logic             ovf_nx;
  logic             accept;
  logic             step;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN:  if (last)      state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == RUN);
    accept       = (state == IDLE) && bus.start;
    step         = (state == RUN);
    bus.done     = done_q;
    bus.sum      = sum_q;
    bus.cout     = cout_q;
    bus.overflow = ovf_q;
  end

  // Carry into the MSB is recovered as a^b^s of the top bit.
  always_comb begin
    last   = (cnt == CW'(N - 1));
    dsum   = {1'b0, ra[DIGIT-1:0]}
           + {1'b0, rb[DIGIT-1:0]}
           + (DIGIT+1)'(carry);
    res_nx = (res >> DIGIT)
           | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    ovf_nx = ra[DIGIT-1] ^ rb[DIGIT-1]
           ^ dsum[DIGIT-1] ^ dsum[DIGIT];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      carry  <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        ra    <= bus.a;
        rb    <= bus.b ^ {WIDTH{bus.sub}};
        carry <= bus.cin ^ bus.sub;
        cnt   <= '0;
      end else if (step) begin
        ra    <= ra >> DIGIT;
        rb    <= rb >> DIGIT;
        res   <= res_nx;
        carry <= dsum[DIGIT];
        cnt   <= last ? '0 : cnt + 1'b1;
        if (last) begin
          done_q <= 1'b1;
          sum_q  <= res_nx;
          cout_q <= dsum[DIGIT];
          ovf_q  <= ovf_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: DIGIT=1 and DIGIT=8 instances
// checked against a plain-arithmetic reference model.
module tb_bit_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(64)) i1 ();
  bit_serial_adder_if #(.WIDTH(64)) i8 ();

  bit_serial_adder #(.WIDTH(64), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1)
  );
  bit_serial_adder #(.WIDTH(64), .DIGIT(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(i8)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // {overflow, cout, sum} from the arithmetic definitions
  function automatic logic [65:0] model(logic s,
      logic [63:0] a, logic [63:0] b, logic c);
    logic [64:0] f;
    logic co, ov;
    if (!s) begin
      f  = {1'b0, a} + {1'b0, b} + 65'(c);
      co = f[64];
      ov = (a[63] == b[63]) && (f[63] != a[63]);
    end else begin
      f  = {1'b0, a} - {1'b0, b} - 65'(c);
      co = ~f[64];
      ov = (a[63] != b[63]) && (f[63] != a[63]);
    end
    return {ov, co, f[63:0]};
  endfunction

  function automatic logic get_done(int sel);
    return (sel == 1) ? i1.done : i8.done;
  endfunction

  function automatic logic get_busy(int sel);
    return (sel == 1) ? i1.busy : i8.busy;
  endfunction

  function automatic logic [65:0] get_res(int sel);
    if (sel == 1) return {i1.overflow, i1.cout, i1.sum};
    return {i8.overflow, i8.cout, i8.sum};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int sel, logic st, logic s,
      logic [63:0] a, logic [63:0] b, logic c);
    if (sel == 1) begin
      i1.start = st; i1.sub = s; i1.a = a; i1.b = b; i1.cin = c;
    end else begin
      i8.start = st; i8.sub = s; i8.a = a; i8.b = b; i8.cin = c;
    end
  endtask

  task automatic launch(int sel, logic s,
      logic [63:0] a, logic [63:0] b, logic c);
    drive(sel, 1'b1, s, a, b, c);
    step();
    drive(sel, 1'b0, 1'($urandom), {$urandom, $urandom},
          {$urandom, $urandom}, 1'($urandom));
  endtask

  task automatic wait_done(int sel, output int cyc,
                           output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!get_done(sel) && cyc < 300) begin
      if (get_busy(sel)) bcnt++;
      step();
      cyc++;
    end
  endtask

  task automatic check_res(int sel, string tag, logic s,
      logic [63:0] a, logic [63:0] b, logic c);
    logic [65:0] e;
    logic [65:0] g;
    e = model(s, a, b, c);
    g = get_res(sel);
    check({tag, " sum"},  g[63:0],     e[63:0]);
    check({tag, " cout"}, 64'(g[64]),  64'(e[64]));
    check({tag, " ovf"},  64'(g[65]),  64'(e[65]));
  endtask

  task automatic op(int sel, string tag, logic s,
      logic [63:0] a, logic [63:0] b, logic c);
    int cyc, bcnt, n;
    n = (sel == 1) ? 64 : 8;
    launch(sel, s, a, b, c);
    wait_done(sel, cyc, bcnt);
    check({tag, " done"},    64'(get_done(sel)), 64'd1);
    check({tag, " latency"}, 64'(cyc),  64'(n));
    check({tag, " busycyc"}, 64'(bcnt), 64'(n));
    check_res(sel, tag, s, a, b, c);
    step();
    check({tag, " doneclr"}, 64'(get_done(sel)), 64'd0);
  endtask

  task automatic check_zero(int sel, string tag);
    check({tag, " busy"}, 64'(get_busy(sel)), 64'd0);
    check({tag, " done"}, 64'(get_done(sel)), 64'd0);
    check({tag, " outs"}, 64'(get_res(sel)), 64'd0);
  endtask

  initial begin
    int c1, b1, c2, b2, nd;
    logic [63:0] ra, rb;
    logic        rs, rc;
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(8, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) step();
    check_zero(1, "rst d1");
    check_zero(8, "rst d8");
    rst_n = 1'b1;
    step();

    op(1, "2+5", 1'b0, 64'd2, 64'd5, 1'b0);
    check("2+5 const", i1.sum, 64'd7);
    op(1, "1234+1123", 1'b0, 64'd1234, 64'd1123, 1'b0);
    check("1234+1123 const", i1.sum, 64'd2357);
    op(1, "20+2012+1", 1'b0, 64'd20, 64'd2012, 1'b1);
    check("20+2012+1 const", i1.sum, 64'd2033);
    op(1, "ffff+1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("ffff+1 flags", 64'({i1.overflow, i1.cout}), 64'b01);
    op(1, "7fff+1", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("7fff+1 flags", 64'({i1.overflow, i1.cout}), 64'b10);
    check("7fff+1 const", i1.sum, 64'h8000_0000_0000_0000);
    op(1, "75-75123", 1'b1, 64'd75, 64'd75123, 1'b0);
    check("75-75123 const", i1.sum, 64'd0 - 64'd75048);
    op(1, "200-128-1", 1'b1, 64'd200, 64'd128, 1'b1);
    check("200-128-1 const", i1.sum, 64'd71);

    op(8, "d8 128+12890", 1'b0, 64'd128, 64'd12890, 1'b0);
    check("d8 const", i8.sum, 64'd13018);

    // second start issued in the cycle done is high
    launch(8, 1'b0, 64'd128, 64'd12890, 1'b0);
    wait_done(8, c1, b1);
    check("b2b first lat", 64'(c1), 64'd8);
    check_res(8, "b2b first", 1'b0, 64'd128, 64'd12890, 1'b0);
    launch(8, 1'b0, 64'd200, 64'd20123, 1'b0);
    wait_done(8, c2, b2);
    check("b2b second cyc", 64'(c1 + 1 + c2), 64'd17);
    check("b2b second sum", i8.sum, 64'd20323);
    step();

    launch(1, 1'b0, 64'd1000, 64'd2345, 1'b0);
    step();
    step();
    drive(1, 1'b1, 1'b1, 64'd999, 64'd5, 1'b1);
    step();
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    wait_done(1, c1, b1);
    check("busy-start lat", 64'(c1 + 3), 64'd64);
    check_res(1, "busy-start", 1'b0, 64'd1000, 64'd2345, 1'b0);
    nd = 0;
    repeat (70) begin
      step();
      if (i1.done) nd++;
    end
    check("busy-start extra done", 64'(nd), 64'd0);
    check("busy-start idle", 64'(i1.busy), 64'd0);

    launch(1, 1'b0, 64'd55, 64'd66, 1'b0);
    repeat (29) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_zero(1, "midrst");
    nd = 0;
    repeat (70) begin
      step();
      if (i1.done) nd++;
    end
    check("midrst no done", 64'(nd), 64'd0);
    op(1, "post-rst", 1'b1, 64'd5000, 64'd123, 1'b1);

    drive(1, 1'b1, 1'b0, 64'd3, 64'd4, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    check_zero(1, "rst+start");
    step();
    check("rst+start busy", 64'(i1.busy), 64'd0);

    for (int k = 0; k < 10; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom);
      rc = 1'($urandom);
      op((k % 2 == 0) ? 1 : 8, $sformatf("rnd%0d", k),
         rs, ra, rb, rc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
